mms_seq_ctrl: RTL and testbench
===============================

MMS_SEQ_CTRL -- requirements
Module: mms_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the data element width in bits.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, giving the maximum frame length in elements.
REQ-003 Port clk SHALL be input, 1 bit: the single clock.
REQ-004 Port rst SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005 Port start SHALL be input, 1 bit: frame start request.
REQ-006 Port select SHALL be input, 1 bit: mode; 0 = max, 1 = min; sampled with start.
REQ-007 Port len SHALL be input, $clog2(MAX_LEN)+1 bits: frame length, 1..MAX_LEN; sampled with start.
REQ-008 Ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, DW bits) SHALL form the element input handshake.
REQ-009 Ports out_valid (output, 1 bit), out_ready (input, 1 bit) and result (output, DW bits) SHALL form the result output handshake.
REQ-010 Port busy SHALL be output, 1 bit: high whenever the block is not in IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-012 In IDLE, start=1 with len in 1..MAX_LEN SHALL latch select and len, clear the element counter, and move to ACCUM on the next edge.
REQ-013 In IDLE, start=1 with len=0 or len>MAX_LEN SHALL be ignored; the block stays in IDLE.
REQ-014 start SHALL be ignored in ACCUM and DONE; the latched select and len stay fixed for the whole frame.
REQ-015 in_ready SHALL be 1 only in ACCUM; an element is accepted on each cycle with in_valid & in_ready.
REQ-016 The first accepted element SHALL load the best register unconditionally.
REQ-017 Each later accepted element SHALL replace best only when it is strictly greater (select=0) or strictly less (select=1); on a tie the earlier element is kept.
REQ-018 Compares SHALL be unsigned over DW bits.
REQ-019 When the len-th element is accepted, the FSM SHALL enter DONE on the next edge; result is therefore valid one cycle after the last accepted element.
REQ-020 Throughput SHALL be one element per cycle with no bubbles between elements.
REQ-021 In DONE, out_valid SHALL be 1 and result SHALL equal best, held stable until out_ready=1.
REQ-022 The handshake out_valid & out_ready SHALL return the FSM to IDLE; a start in that same cycle is ignored.
REQ-023 A frame of len=1 SHALL return its single element as result.
REQ-024 The element counter SHALL never wrap; len=MAX_LEN SHALL complete normally.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, counter=0, best=0, latched select=0 and latched len=0.
REQ-026 While reset is in effect, in_ready, out_valid and busy SHALL all read 0 and result SHALL read 0.
REQ-027 A reset in mid-frame SHALL abandon the frame; no partial result is produced.

Configuration
REQ-028 With macro MMS_SEQ_CTRL_INDEX_EN defined, the block SHALL add output out_index ($clog2(MAX_LEN) bits), which gives the 0-based position within the frame of the element held in best; it follows the tie rule of REQ-017, is valid with out_valid, and resets to 0.
REQ-029 Without MMS_SEQ_CTRL_INDEX_EN, out_index and its register SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 Package mms_pkg SHALL hold the DW and MAX_LEN default constants and the FSM state enum type (IDLE, ACCUM, DONE).
REQ-031 The compare-select SHALL be one combinational sub-module, mms_cmp_sel (inputs a, b, select; outputs the chosen value and a take_b flag), instantiated once.

Verification
REQ-032 The bench SHALL cover: select=0, len=4, elements 3,9,2,7 -> result=9 one cycle after the 4th accept (out_index=1 with MMS_SEQ_CTRL_INDEX_EN).
REQ-033 The bench SHALL cover: select=1, len=8, elements 50,20,20,80,255,0,0,5 -> result=0 (out_index=5 with MMS_SEQ_CTRL_INDEX_EN).
REQ-034 The bench SHALL cover: start with len=0 -> busy stays 0 and in_ready stays 0; then len=1 with element 0xAB -> result=0xAB.
REQ-035 The bench SHALL cover: in_valid toggled every other cycle and out_ready held 0 for 5 cycles in DONE -> result stable and out_valid held; start pulses during ACCUM and DONE have no effect.
REQ-036 The bench SHALL cover: rst asserted after 2 of 4 elements -> next-cycle outputs all 0 and IDLE; a new frame with select=0 and elements 1,1 -> result=1.
REQ-037 The bench SHALL cover: len=16, elements 0..15 with select=0 -> result=15, checking that the counter does not wrap.

Source files
------------

// File: rtl/mms_pkg.sv
// mms_pkg: shared default constants and FSM state type for the min/max sequence controller.
package mms_pkg;
  localparam int DW_DEF = 8;
  localparam int MAX_LEN_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/mms_cmp_sel.sv
// mms_cmp_sel: unsigned compare-select; take_b flags a strictly better b (greater for select=0, less for select=1).
module mms_cmp_sel import mms_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          select,
  output logic [DW-1:0] y,
  output logic          take_b
);
  always_comb begin
    take_b = select ? (b < a) : (b > a);
    y = take_b ? b : a;
  end
endmodule

// File: rtl/mms_seq_ctrl.sv
// mms_seq_ctrl: streaming min/max reducer over a frame of len elements with valid/ready handshakes.
// Define MMS_SEQ_CTRL_INDEX_EN to add out_index, the frame position of the selected element.
module mms_seq_ctrl import mms_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      select,
  input  logic [$clog2(MAX_LEN):0]  len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             result,
`ifdef MMS_SEQ_CTRL_INDEX_EN
  output logic [$clog2(MAX_LEN)-1:0] out_index,
`endif
  output logic                      busy
);
  localparam int LW = $clog2(MAX_LEN) + 1;
  state_t state, nxt;
  logic [LW-1:0] cnt, len_q;
  logic [DW-1:0] best, cand, cmp_a;
  logic sel_q, take_b, start_ok, accept, last, first, upd;
  assign start_ok = start && len != '0 && len <= LW'(MAX_LEN);
  assign accept = in_valid && in_ready;
  assign first = cnt == '0;
  assign last = accept && cnt == len_q - LW'(1);
  // The first element is compared against itself so it always lands in best.
  assign cmp_a = first ? in_data : best;
  assign upd = accept && (first || take_b);
  mms_cmp_sel #(.DW(DW)) u_cmp (
    .a(cmp_a),
    .b(in_data),
    .select(sel_q),
    .y(cand),
    .take_b(take_b)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (start_ok ? ACCUM : IDLE)
        : state == ACCUM ? (last ? DONE : ACCUM)
        : (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = !rst && state == ACCUM;
    out_valid = !rst && state == DONE;
    busy = !rst && state != IDLE;
    result = rst ? '0 : best;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      best <= '0;
      sel_q <= 1'b0;
      len_q <= '0;
`ifdef MMS_SEQ_CTRL_INDEX_EN
      out_index <= '0;
`endif
    end else begin
      if (state == IDLE && start_ok) begin
        sel_q <= select;
        len_q <= len;
        cnt <= '0;
      end
      if (accept) cnt <= cnt + LW'(1);
      if (upd) begin
        best <= cand;
`ifdef MMS_SEQ_CTRL_INDEX_EN
        out_index <= cnt[LW-2:0];
`endif
      end
    end
endmodule

// File: tb/tb_mms_seq_ctrl.sv
// tb_mms_seq_ctrl: randomized scoreboard bench for mms_seq_ctrl; out_index is also checked when MMS_SEQ_CTRL_INDEX_EN is defined.
`timescale 1ns/1ps
module tb_mms_seq_ctrl;
  localparam int DW = 8;
  localparam int MAX_LEN = 16;
  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam int IW = $clog2(MAX_LEN);
  typedef struct {
    logic [DW-1:0] res;
    int idx;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, select = 0, in_valid = 0, out_ready = 0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [DW-1:0] result;
`ifdef MMS_SEQ_CTRL_INDEX_EN
  logic [IW-1:0] out_index;
`endif
  int checks = 0, errors = 0;
  exp_t sb[$];
  logic [DW-1:0] frame[$];
  always #5 clk = ~clk;
  mms_seq_ctrl #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .select(select),
    .len(len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
`ifdef MMS_SEQ_CTRL_INDEX_EN
    .out_index(out_index),
`endif
    .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: extreme value of the frame, then its earliest position.
  function automatic exp_t model(input logic s);
    exp_t e;
    e.res = frame[0];
    foreach (frame[i]) if (s ? frame[i] < e.res : frame[i] > e.res) e.res = frame[i];
    e.idx = 0;
    while (frame[e.idx] != e.res) e.idx++;
    return e;
  endfunction
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_result", result, e.res);
`ifdef MMS_SEQ_CTRL_INDEX_EN
        chk("sb_index", out_index, e.idx);
`endif
      end
    end
  task automatic send_frame(input logic s, input bit gap, input int hold);
    exp_t e = model(s);
    int t;
    sb.push_back(e);
    start = 1; select = s; len = LW'(frame.size());
    @(negedge clk);
    start = 0;
    chk("start_busy", busy, 1);
    foreach (frame[i]) begin
      in_valid = 1; in_data = frame[i];
      start = gap ? 1'($urandom) : 1'b0;
      select = 1'($urandom); len = LW'($urandom_range(1, MAX_LEN));
      t = 0;
      while (!in_ready && t < 20) begin @(negedge clk); t++; end
      chk("in_ready", in_ready, 1);
      @(posedge clk); #1;
      if (gap && i != frame.size() - 1) begin
        in_valid = 0; in_data = DW'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 0;
    for (int h = 0; h <= hold; h++) begin
      out_ready = (h == hold);
      start = (h == hold) ? 1'b1 : 1'($urandom);
      len = LW'(3);
      @(negedge clk);
      chk(h == 0 ? "done_latency" : "hold_valid", out_valid, 1);
      chk("hold_result", result, e.res);
      chk("done_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    start = 0; out_ready = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
`ifdef MMS_SEQ_CTRL_INDEX_EN
    chk("rst_index", out_index, 0);
`endif
    rst = 0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    frame = '{3, 9, 2, 7};
    send_frame(0, 0, 0);
    frame = '{50, 20, 20, 80, 255, 0, 0, 5};
    send_frame(1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      start = 1; len = (k == 0) ? LW'(0) : LW'(MAX_LEN + 1);
      @(negedge clk);
      start = 0;
      repeat (3) begin
        @(negedge clk);
        chk("badlen_busy", busy, 0);
        chk("badlen_in_ready", in_ready, 0);
      end
    end
    frame = '{8'hAB};
    send_frame(1'($urandom), 0, 0);
    frame = {};
    repeat (6) frame.push_back(DW'($urandom));
    send_frame(0, 1, 5);
    start = 1; select = 0; len = LW'(4);
    @(negedge clk);
    start = 0;
    chk("abort_busy", busy, 1);
    in_valid = 1; in_data = 8'd5;
    @(negedge clk);
    in_data = 8'd200;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_in_ready", in_ready, 0);
    chk("abort_rst_result", result, 0);
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("abort_busy_after", busy, 0);
    chk("abort_in_ready_after", in_ready, 0);
    chk("abort_out_valid_after", out_valid, 0);
    chk("abort_result_after", result, 0);
    frame = '{1, 1};
    send_frame(0, 0, 0);
    frame = {};
    for (int i = 0; i < MAX_LEN; i++) frame.push_back(DW'(i));
    send_frame(0, 0, 2);
    repeat (20) begin
      frame = {};
      repeat ($urandom_range(1, MAX_LEN)) frame.push_back(DW'($urandom_range(0, 15) * 17));
      send_frame(1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
